// File: rtl/hpdcache_pkg.sv
// Shared HPDcache request types plus the CMO opcode encoding and its
// conversion to the CMO handler's one-hot operation.
package hpdcache_pkg;
   localparam int unsigned HPDCACHE_PA_WIDTH   = 40;
   localparam int unsigned HPDCACHE_WORD_WIDTH = 64;
   localparam int unsigned HPDCACHE_REQ_WORDS  = 2;
   localparam int unsigned HPDCACHE_WAYS       = 8;

   typedef logic [HPDCACHE_PA_WIDTH-1:0] hpdcache_req_addr_t;
   typedef logic [HPDCACHE_REQ_WORDS-1:0][HPDCACHE_WORD_WIDTH-1:0] hpdcache_req_data_t;
   typedef logic [HPDCACHE_WAYS-1:0] hpdcache_way_vector_t;

   typedef struct packed {
      logic is_fence;
      logic is_inval_by_nline;
      logic is_inval_by_set;
      logic is_inval_all;
   } hpdcache_cmoh_op_t;

   // Codes 4..7 are illegal and carry no enum label.
   typedef enum logic [2:0] {
      HPDCACHE_CMO_FENCE       = 3'd0,
      HPDCACHE_CMO_INVAL_NLINE = 3'd1,
      HPDCACHE_CMO_INVAL_SET   = 3'd2,
      HPDCACHE_CMO_INVAL_ALL   = 3'd3
   } hpdcache_cmo_opcode_t;

   function automatic hpdcache_cmoh_op_t hpdcache_cmo_to_cmoh_op(input hpdcache_cmo_opcode_t op);
      hpdcache_cmoh_op_t r;
      r = '0;
      case (op)
         HPDCACHE_CMO_FENCE:       r.is_fence          = 1'b1;
         HPDCACHE_CMO_INVAL_NLINE: r.is_inval_by_nline = 1'b1;
         HPDCACHE_CMO_INVAL_SET:   r.is_inval_by_set   = 1'b1;
         HPDCACHE_CMO_INVAL_ALL:   r.is_inval_all      = 1'b1;
         default:                  r                   = '0;
      endcase
      return r;
   endfunction
endpackage

// File: rtl/hpdcache_cmo_dispatch.sv
// CMO dispatcher: registers one core CMO request, issues it to the CMO
// handler, waits for the handler to go idle and returns a tagged response.
//
// state | meaning
// IDLE  | ready for a new core request
// ISSUE | request presented to the handler, waiting for handshake
// WAIT  | handler busy; completion when its ready (idle) returns
// RESP  | response presented to the core, waiting for handshake
module hpdcache_cmo_dispatch
   import hpdcache_pkg::*;
#(
   parameter int unsigned SID_WIDTH      = 3,
   parameter int unsigned TID_WIDTH      = 6,
   parameter int unsigned WAIT_CNT_WIDTH = 16
)(
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      core_req_valid_i,
   output logic                      core_req_ready_o,
   input  logic [2:0]                core_req_op_i,
   input  hpdcache_req_addr_t        core_req_addr_i,
   input  hpdcache_req_data_t        core_req_wdata_i,
   input  logic [SID_WIDTH-1:0]      core_req_sid_i,
   input  logic [TID_WIDTH-1:0]      core_req_tid_i,
   input  logic                      core_req_need_rsp_i,
   output logic                      cmoh_req_valid_o,
   input  logic                      cmoh_req_ready_i,
   output hpdcache_cmoh_op_t         cmoh_req_op_o,
   output hpdcache_req_addr_t        cmoh_req_addr_o,
   output hpdcache_req_data_t        cmoh_req_wdata_o,
   input  logic                      cmoh_req_wait_i,
   output logic                      core_rsp_valid_o,
   input  logic                      core_rsp_ready_i,
   output logic [SID_WIDTH-1:0]      core_rsp_sid_o,
   output logic [TID_WIDTH-1:0]      core_rsp_tid_o,
   output logic                      core_rsp_error_o,
   output logic                      busy_o,
   output logic [WAIT_CNT_WIDTH-1:0] wait_cnt_o
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e                    state_q, state_d;
   hpdcache_cmo_opcode_t      op_q;
   hpdcache_req_addr_t        addr_q;
   hpdcache_req_data_t        wdata_q;
   logic [SID_WIDTH-1:0]      sid_q;
   logic [TID_WIDTH-1:0]      tid_q;
   logic                      need_rsp_q;
   logic                      err_q;
   logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q;
   logic                      accept;
   logic                      req_illegal;

   assign accept      = (state_q == IDLE) && core_req_valid_i;
   assign req_illegal = (core_req_op_i > 3'd3);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == WAIT) && cmoh_req_wait_i && (wait_cnt_q != '1))
            wait_cnt_q <= wait_cnt_q + 1'b1;
      end
   end

   // Payload is only meaningful behind a valid, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         op_q       <= hpdcache_cmo_opcode_t'(core_req_op_i);
         addr_q     <= core_req_addr_i;
         wdata_q    <= core_req_wdata_i;
         sid_q      <= core_req_sid_i;
         tid_q      <= core_req_tid_i;
         need_rsp_q <= core_req_need_rsp_i;
         err_q      <= req_illegal;
      end
   end

   always_comb begin
      state_d          = state_q;
      core_req_ready_o = 1'b0;
      cmoh_req_valid_o = 1'b0;
      core_rsp_valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            core_req_ready_o = 1'b1;
            if (core_req_valid_i) begin
               if (req_illegal) state_d = core_req_need_rsp_i ? RESP : IDLE;
               else             state_d = ISSUE;
            end
         end
         ISSUE: begin
            cmoh_req_valid_o = 1'b1;
            if (cmoh_req_ready_i) state_d = WAIT;
         end
         WAIT: begin
            if (cmoh_req_ready_i) state_d = need_rsp_q ? RESP : IDLE;
         end
         RESP: begin
            core_rsp_valid_o = 1'b1;
            if (core_rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cmoh_req_op_o    = hpdcache_cmo_to_cmoh_op(op_q);
   assign cmoh_req_addr_o  = addr_q;
   assign cmoh_req_wdata_o = wdata_q;
   assign core_rsp_sid_o   = sid_q;
   assign core_rsp_tid_o   = tid_q;
   assign core_rsp_error_o = err_q;
   assign busy_o           = (state_q != IDLE);
   assign wait_cnt_o       = wait_cnt_q;

   a_op_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
      cmoh_req_valid_o |-> $onehot(cmoh_req_op_o));
   a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      cmoh_req_valid_o && !cmoh_req_ready_i |=>
         cmoh_req_valid_o && $stable({cmoh_req_op_o, cmoh_req_addr_o, cmoh_req_wdata_o}));
   a_rsp_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      core_rsp_valid_o && !core_rsp_ready_i |=>
         core_rsp_valid_o && $stable({core_rsp_sid_o, core_rsp_tid_o, core_rsp_error_o}));
endmodule

// File: tb/tb_hpdcache_cmo_dispatch.sv
// Directed scoreboard bench for hpdcache_cmo_dispatch; a second instance with
// a 4-bit wait counter shares the stimulus to exercise saturation.
module tb_hpdcache_cmo_dispatch;
   import hpdcache_pkg::*;

   logic clk_i = 1'b0;
   logic rst_ni;
   always #5 clk_i = ~clk_i;

   logic               core_req_valid_i, core_req_need_rsp_i;
   logic [2:0]         core_req_op_i;
   hpdcache_req_addr_t core_req_addr_i;
   hpdcache_req_data_t core_req_wdata_i;
   logic [2:0]         core_req_sid_i;
   logic [5:0]         core_req_tid_i;
   logic               cmoh_req_ready_i, cmoh_req_wait_i, core_rsp_ready_i;

   logic               core_req_ready_o, cmoh_req_valid_o, core_rsp_valid_o;
   hpdcache_cmoh_op_t  cmoh_req_op_o;
   hpdcache_req_addr_t cmoh_req_addr_o;
   hpdcache_req_data_t cmoh_req_wdata_o;
   logic [2:0]         core_rsp_sid_o;
   logic [5:0]         core_rsp_tid_o;
   logic               core_rsp_error_o, busy_o;
   logic [15:0]        wait_cnt_o;

   logic               s_req_ready, s_cmoh_valid, s_rsp_valid, s_rsp_error, s_busy;
   hpdcache_cmoh_op_t  s_cmoh_op;
   hpdcache_req_addr_t s_cmoh_addr;
   hpdcache_req_data_t s_cmoh_wdata;
   logic [2:0]         s_rsp_sid;
   logic [5:0]         s_rsp_tid;
   logic [3:0]         s_wait_cnt;

   hpdcache_cmo_dispatch #(.SID_WIDTH(3), .TID_WIDTH(6), .WAIT_CNT_WIDTH(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
      .core_req_op_i(core_req_op_i), .core_req_addr_i(core_req_addr_i),
      .core_req_wdata_i(core_req_wdata_i), .core_req_sid_i(core_req_sid_i),
      .core_req_tid_i(core_req_tid_i), .core_req_need_rsp_i(core_req_need_rsp_i),
      .cmoh_req_valid_o(cmoh_req_valid_o), .cmoh_req_ready_i(cmoh_req_ready_i),
      .cmoh_req_op_o(cmoh_req_op_o), .cmoh_req_addr_o(cmoh_req_addr_o),
      .cmoh_req_wdata_o(cmoh_req_wdata_o), .cmoh_req_wait_i(cmoh_req_wait_i),
      .core_rsp_valid_o(core_rsp_valid_o), .core_rsp_ready_i(core_rsp_ready_i),
      .core_rsp_sid_o(core_rsp_sid_o), .core_rsp_tid_o(core_rsp_tid_o),
      .core_rsp_error_o(core_rsp_error_o), .busy_o(busy_o), .wait_cnt_o(wait_cnt_o)
   );

   hpdcache_cmo_dispatch #(.SID_WIDTH(3), .TID_WIDTH(6), .WAIT_CNT_WIDTH(4)) dut_sat (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .core_req_valid_i(core_req_valid_i), .core_req_ready_o(s_req_ready),
      .core_req_op_i(core_req_op_i), .core_req_addr_i(core_req_addr_i),
      .core_req_wdata_i(core_req_wdata_i), .core_req_sid_i(core_req_sid_i),
      .core_req_tid_i(core_req_tid_i), .core_req_need_rsp_i(core_req_need_rsp_i),
      .cmoh_req_valid_o(s_cmoh_valid), .cmoh_req_ready_i(cmoh_req_ready_i),
      .cmoh_req_op_o(s_cmoh_op), .cmoh_req_addr_o(s_cmoh_addr),
      .cmoh_req_wdata_o(s_cmoh_wdata), .cmoh_req_wait_i(cmoh_req_wait_i),
      .core_rsp_valid_o(s_rsp_valid), .core_rsp_ready_i(core_rsp_ready_i),
      .core_rsp_sid_o(s_rsp_sid), .core_rsp_tid_o(s_rsp_tid),
      .core_rsp_error_o(s_rsp_error), .busy_o(s_busy), .wait_cnt_o(s_wait_cnt)
   );

   typedef struct packed {
      logic [3:0]         op;
      hpdcache_req_addr_t addr;
      hpdcache_req_data_t wdata;
   } iss_t;
   typedef struct packed {
      logic [2:0] sid;
      logic [5:0] tid;
      logic       err;
   } rsp_t;

   iss_t iss_q[$];
   rsp_t rsp_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected one-hot, bit order {fence, inval_nline, inval_set, inval_all}.
   function automatic logic [3:0] exp_onehot(input logic [2:0] op);
      case (op)
         3'd0:    return 4'b1000;
         3'd1:    return 4'b0100;
         3'd2:    return 4'b0010;
         3'd3:    return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input hpdcache_req_addr_t a, input hpdcache_req_data_t d,
                       input logic [2:0] sid, input logic [5:0] tid, input logic need);
      iss_t e;
      rsp_t r;
      core_req_valid_i    = 1'b1;
      core_req_op_i       = op;
      core_req_addr_i     = a;
      core_req_wdata_i    = d;
      core_req_sid_i      = sid;
      core_req_tid_i      = tid;
      core_req_need_rsp_i = need;
      if (op < 3'd4) begin
         e.op = exp_onehot(op); e.addr = a; e.wdata = d;
         iss_q.push_back(e);
      end
      if (need) begin
         r.sid = sid; r.tid = tid; r.err = (op > 3'd3);
         rsp_q.push_back(r);
      end
      tick();
      core_req_valid_i = 1'b0;
   endtask

   task automatic chk_issue(input string tag);
      iss_t e;
      chk({tag, "_pending"}, 128'(iss_q.size() > 0), 128'd1);
      e = iss_q.pop_front();
      chk({tag, "_valid"}, 128'(cmoh_req_valid_o), 128'd1);
      chk({tag, "_op"},    128'(cmoh_req_op_o),    128'(e.op));
      chk({tag, "_addr"},  128'(cmoh_req_addr_o),  128'(e.addr));
      chk({tag, "_wdata"}, cmoh_req_wdata_o,       e.wdata);
   endtask

   task automatic chk_rsp(input string tag);
      rsp_t r;
      chk({tag, "_pending"}, 128'(rsp_q.size() > 0), 128'd1);
      r = rsp_q.pop_front();
      chk({tag, "_valid"}, 128'(core_rsp_valid_o), 128'd1);
      chk({tag, "_sid"},   128'(core_rsp_sid_o),   128'(r.sid));
      chk({tag, "_tid"},   128'(core_rsp_tid_o),   128'(r.tid));
      chk({tag, "_err"},   128'(core_rsp_error_o), 128'(r.err));
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int                 extra_issues;
      hpdcache_req_data_t d;
      rst_ni = 1'b0;
      core_req_valid_i = 1'b0; core_req_op_i = '0; core_req_addr_i = '0; core_req_wdata_i = '0;
      core_req_sid_i = '0; core_req_tid_i = '0; core_req_need_rsp_i = 1'b0;
      cmoh_req_ready_i = 1'b1; cmoh_req_wait_i = 1'b0; core_rsp_ready_i = 1'b1;
      tick(); tick();

      chk("rst_req_ready",  128'(core_req_ready_o), 128'd1);
      chk("rst_cmoh_valid", 128'(cmoh_req_valid_o), 128'd0);
      chk("rst_rsp_valid",  128'(core_rsp_valid_o), 128'd0);
      chk("rst_busy",       128'(busy_o),           128'd0);
      chk("rst_wait_cnt",   128'(wait_cnt_o),       128'd0);
      rst_ni = 1'b1;
      tick();

      // FENCE with the handler always ready: minimum latency path.
      d = '0; d[0] = 64'h1234;
      send(3'd0, 40'h00_1000_0040, d, 3'd2, 6'd5, 1'b1);
      chk_issue("fence_issue");
      chk("fence_req_ready_t1", 128'(core_req_ready_o), 128'd0);
      chk("fence_busy_t1", 128'(busy_o), 128'd1);
      tick();
      chk("fence_cmoh_pulse", 128'(cmoh_req_valid_o), 128'd0);
      chk("fence_rsp_t2",     128'(core_rsp_valid_o), 128'd0);
      tick();
      chk_rsp("fence_rsp");
      tick();
      chk("fence_rsp_done", 128'(core_rsp_valid_o), 128'd0);
      chk("fence_idle",     128'(core_req_ready_o), 128'd1);

      // INVAL_ALL, handler busy for 64 WAIT cycles, 10 of them waiting.
      do_reset();
      d = '0;
      send(3'd3, 40'h0, d, 3'd1, 6'd17, 1'b1);
      chk_issue("all_issue");
      tick();
      cmoh_req_ready_i = 1'b0;
      extra_issues = 0;
      for (int i = 0; i < 64; i++) begin
         cmoh_req_wait_i = (i < 10);
         if (cmoh_req_valid_o) extra_issues++;
         tick();
      end
      cmoh_req_wait_i = 1'b0;
      chk("all_single_issue", 128'(extra_issues), 128'd0);
      chk("all_rsp_before_ready", 128'(core_rsp_valid_o), 128'd0);
      cmoh_req_ready_i = 1'b1;
      tick();
      chk_rsp("all_rsp");
      chk("all_wait_cnt",     128'(wait_cnt_o), 128'd10);
      chk("all_wait_cnt_sat", 128'(s_wait_cnt), 128'd10);
      tick();

      // INVAL_SET, handler not ready for the first three ISSUE cycles.
      cmoh_req_ready_i = 1'b0;
      d = '0; d[0] = 64'h0F; d[1] = 64'hDEAD_BEEF;
      send(3'd2, 40'hAB_CDEF_0100, d, 3'd4, 6'd9, 1'b1);
      chk_issue("set_issue_c1");
      for (int c = 2; c <= 4; c++) begin
         tick();
         if (c == 4) cmoh_req_ready_i = 1'b1;
         chk("set_hold_valid", 128'(cmoh_req_valid_o), 128'd1);
         chk("set_hold_op",    128'(cmoh_req_op_o),    128'(4'b0010));
         chk("set_hold_addr",  128'(cmoh_req_addr_o),  128'(40'hAB_CDEF_0100));
         chk("set_hold_wdata", cmoh_req_wdata_o,       d);
      end
      tick();
      chk("set_wait_valid", 128'(cmoh_req_valid_o), 128'd0);
      tick();
      chk_rsp("set_rsp");
      tick();

      // Illegal op, with and without a response.
      send(3'd6, 40'h5, d, 3'd3, 6'd42, 1'b1);
      chk_rsp("ill_rsp");
      chk("ill_cmoh_valid", 128'(cmoh_req_valid_o), 128'd0);
      tick();
      send(3'd6, 40'h5, d, 3'd3, 6'd43, 1'b0);
      chk("ill_nr_ready",      128'(core_req_ready_o), 128'd1);
      chk("ill_nr_busy",       128'(busy_o),           128'd0);
      chk("ill_nr_rsp_valid",  128'(core_rsp_valid_o), 128'd0);
      chk("ill_nr_cmoh_valid", 128'(cmoh_req_valid_o), 128'd0);

      // Response backpressure with a second request waiting.
      core_rsp_ready_i = 1'b0;
      d = '0; d[0] = 64'h77;
      send(3'd1, 40'h12_3456_7800, d, 3'd7, 6'd33, 1'b1);
      chk_issue("bp_issue");
      tick();
      tick();
      chk_rsp("bp_rsp");
      core_req_valid_i = 1'b1; core_req_op_i = 3'd0; core_req_need_rsp_i = 1'b1;
      core_req_sid_i = 3'd6; core_req_tid_i = 6'd1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_hold_valid", 128'(core_rsp_valid_o), 128'd1);
         chk("bp_hold_sid",   128'(core_rsp_sid_o),   128'd7);
         chk("bp_hold_tid",   128'(core_rsp_tid_o),   128'd33);
         chk("bp_hold_err",   128'(core_rsp_error_o), 128'd0);
         chk("bp_req_ready",  128'(core_req_ready_o), 128'd0);
      end
      core_rsp_ready_i = 1'b1;
      tick();
      chk("bp_after_hs_ready", 128'(core_req_ready_o), 128'd1);
      chk("bp_after_hs_rsp",   128'(core_rsp_valid_o), 128'd0);
      send(3'd0, 40'h99, d, 3'd6, 6'd1, 1'b1);
      chk_issue("bp_second_issue");
      tick();
      tick();
      chk_rsp("bp_second_rsp");
      tick();

      // Counter saturation in the 4-bit instance, then reset mid-WAIT.
      do_reset();
      cmoh_req_ready_i = 1'b1;
      send(3'd3, 40'h0, d, 3'd5, 6'd60, 1'b1);
      chk_issue("sat_issue");
      tick();
      cmoh_req_ready_i = 1'b0;
      cmoh_req_wait_i  = 1'b1;
      repeat (20) tick();
      chk("sat_cnt_wide",  128'(wait_cnt_o), 128'd20);
      chk("sat_cnt_small", 128'(s_wait_cnt), 128'd15);
      chk("sat_busy",      128'(busy_o),     128'd1);
      #2 rst_ni = 1'b0;
      #1;
      rsp_q.delete();
      chk("mid_rst_cmoh_valid", 128'(cmoh_req_valid_o), 128'd0);
      chk("mid_rst_rsp_valid",  128'(core_rsp_valid_o), 128'd0);
      chk("mid_rst_busy",       128'(busy_o),           128'd0);
      chk("mid_rst_ready",      128'(core_req_ready_o), 128'd1);
      chk("mid_rst_cnt",        128'(wait_cnt_o),       128'd0);
      chk("mid_rst_cnt_small",  128'(s_wait_cnt),       128'd0);
      cmoh_req_wait_i  = 1'b0;
      cmoh_req_ready_i = 1'b1;
      tick();
      rst_ni = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("post_rst_rsp_valid", 128'(core_rsp_valid_o), 128'd0);
         chk("post_rst_busy",      128'(busy_o),           128'd0);
      end

      chk("sb_iss_empty", 128'(iss_q.size()), 128'd0);
      chk("sb_rsp_empty", 128'(rsp_q.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/hpdcache_cmo_dispatch.md
Name: hpdcache_cmo_dispatch

Overview:
Upstream front-end of the CMO handler. Accepts one encoded CMO request from the core-side request mux and registers it. Converts the opcode to the handler's one-hot op, issues it with a valid/ready handshake, and detects completion when the handler returns to idle. Returns a tagged completion/error response to the requester and counts stall cycles.

Parameters:
SID_WIDTH, 3, requester source-ID width
TID_WIDTH, 6, transaction-ID width
WAIT_CNT_WIDTH, 16, width of the saturating wait-cycle counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
core_req_valid_i  in  1  CMO request valid
core_req_ready_o  out  1  dispatcher can accept a request
core_req_op_i  in  3  encoded opcode: 0 FENCE, 1 INVAL_NLINE, 2 INVAL_SET, 3 INVAL_ALL, 4-7 illegal
core_req_addr_i  in  hpdcache_req_addr_t  target address
core_req_wdata_i  in  hpdcache_req_data_t  parameters; word 0 bits [WAYS-1:0] hold the way mask
core_req_sid_i  in  SID_WIDTH  source ID
core_req_tid_i  in  TID_WIDTH  transaction ID
core_req_need_rsp_i  in  1  requester wants a response
cmoh_req_valid_o  out  1  request to the CMO handler
cmoh_req_ready_i  in  1  handler idle/ready
cmoh_req_op_o  out  hpdcache_cmoh_op_t  one-hot op
cmoh_req_addr_o  out  hpdcache_req_addr_t  registered address
cmoh_req_wdata_o  out  hpdcache_req_data_t  registered wdata
cmoh_req_wait_i  in  1  handler is waiting on drain (fence/inval)
core_rsp_valid_o  out  1  response valid
core_rsp_ready_i  in  1  response accepted
core_rsp_sid_o  out  SID_WIDTH  echoed sid
core_rsp_tid_o  out  TID_WIDTH  echoed tid
core_rsp_error_o  out  1  illegal opcode
busy_o  out  1  state != IDLE
wait_cnt_o  out  WAIT_CNT_WIDTH  cycles spent with cmoh_req_wait_i=1 in WAIT

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset: state=IDLE, wait_cnt=0, all valid outputs 0, busy_o=0. Payload registers are not reset.
- A reset mid-operation drops the in-flight request silently.
- IDLE:
  - core_req_ready_o=1.
  - On valid: register op, addr, wdata, sid, tid, need_rsp, and err=(op>3).
  - If err: go to RESP if need_rsp, else IDLE. The handler is never driven for an illegal op.
  - Otherwise go to ISSUE.
- ISSUE:
  - cmoh_req_valid_o=1, payload stable.
  - Leave ISSUE only when cmoh_req_ready_i=1 (handshake); go to WAIT.
- WAIT:
  - cmoh_req_valid_o=0.
  - Completion is cmoh_req_ready_i=1 in any WAIT cycle. The handler's ready equals idle, so a zero-latency fence completes in the first WAIT cycle.
  - On completion: go to RESP if need_rsp, else IDLE.
  - Each WAIT cycle with cmoh_req_wait_i=1 increments wait_cnt, saturating at all-ones; it never wraps.
- RESP:
  - core_rsp_valid_o=1, sid/tid/error held stable until core_rsp_ready_i.
  - Then go to IDLE.
  - The next request is accepted no earlier than the cycle after the response handshake.
- Op mapping (one-hot, exactly one bit set): 0 to is_fence, 1 to is_inval_by_nline, 2 to is_inval_by_set, 3 to is_inval_all.
- Minimum latency, need_rsp=1, handler ready:
  - accept T, issue T+1, WAIT T+2, rsp_valid T+3.
  - With need_rsp=0: core_req_ready_o returns at T+3.
- core_req_ready_o=0 in ISSUE, WAIT and RESP. No request queueing.
- Assertions:
  - cmoh_req_op_o is onehot while valid.
  - Payload stable while cmoh_req_valid_o && !cmoh_req_ready_i.
  - Response stable while core_rsp_valid_o && !core_rsp_ready_i.

Decomposition:
- The encoded CMO opcode enum (hpdcache_cmo_opcode_t, 3 bits) and its opcode-to-one-hot conversion function go in hpdcache_pkg, next to hpdcache_cmoh_op_t.
- The dispatcher FSM is one flat module.
- The saturating counter is small enough to stay inline; no sub-module.

Test Plan:
- FENCE, need_rsp=1, sid=2 tid=5, handler ready held 1 -> cmoh_req_valid_o pulses one cycle with op=is_fence; rsp_valid at T+3 with sid=2, tid=5, error=0.
- INVAL_ALL, handler ready low for 64 cycles with wait_i=1 for 10 of them -> single issue; response 1 cycle after ready rises; wait_cnt_o=10.
- INVAL_SET, wdata[0]=0x0F, handler ready=0 in ISSUE for 3 cycles -> valid held, addr/wdata stable, op=is_inval_by_set; handshake on the 4th cycle.
- Illegal op=6, need_rsp=1 -> cmoh_req_valid_o never asserted; rsp error=1 at T+1. Same op with need_rsp=0 -> ready again at T+1, no response.
- Response backpressure: core_rsp_ready_i=0 for 5 cycles -> rsp held stable, core_req_ready_o=0 throughout; a second request is accepted only after the handshake.
- Reset asserted in WAIT, and a counter with WAIT_CNT_WIDTH=4 given 20 wait cycles -> reset gives IDLE and all valids 0; the counter saturates at 15.
